// File: rtl/memi_ctrl_pkg.sv
// Shared definitions for the memi controller: widths, controller state encoding
// and starvation counter width.
package memi_ctrl_pkg;

    localparam int MEMI_SIZE_LOG = 3;
    localparam int INST_LEN      = 16;
    localparam int STARVE_CNT_W  = 4;

    typedef enum logic {
        CTRL_RUN  = 1'b0,
        CTRL_LOAD = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/memi_rr_arb.sv
// Two-requester priority arbiter for the memi read port: fetch wins by default,
// debug wins once it has been denied STARVE_LIMIT cycles in a row.
module memi_rr_arb
    import memi_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic fetch_valid,
    input  logic dbg_valid,
    output logic fetch_grant,
    output logic dbg_grant
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    starved;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        starved      = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));
        fetch_grant  = en & fetch_valid & ~(dbg_valid & starved);
        dbg_grant    = en & dbg_valid & (~fetch_valid | starved);
        starve_cnt_d = starve_cnt_q;
        if (!dbg_valid || dbg_grant) begin
            starve_cnt_d = '0;
        end else if (en && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments; the reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/memi_ctrl.sv
// memi controller: arbitrates the single combinational read port between fetch
// and debug, registers read data toward them, and sequences full program loads.
module memi_ctrl
    import memi_ctrl_pkg::*;
#(
    parameter int ADDR_W       = MEMI_SIZE_LOG,
    parameter int DATA_W       = INST_LEN,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_done,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_resp_valid,
    output logic [DATA_W-1:0] fetch_resp_data,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    output logic              dbg_resp_valid,
    output logic [DATA_W-1:0] dbg_resp_data,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              loading
);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              load_done_q, load_done_d;
    logic              fetch_resp_valid_q, fetch_resp_valid_d;
    logic [DATA_W-1:0] fetch_resp_data_q, fetch_resp_data_d;
    logic              dbg_resp_valid_q, dbg_resp_valid_d;
    logic [DATA_W-1:0] dbg_resp_data_q, dbg_resp_data_d;
    logic              arb_en, fetch_grant, dbg_grant;

    assign arb_en = (state_q == CTRL_RUN);

    memi_rr_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (arb_en),
        .fetch_valid(fetch_req_valid),
        .dbg_valid  (dbg_req_valid),
        .fetch_grant(fetch_grant),
        .dbg_grant  (dbg_grant)
    );

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        load_done_d = 1'b0;
        load_ready  = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            CTRL_RUN: begin
                if (load_start) state_d = CTRL_LOAD;
            end
            CTRL_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    // Last entry written: the pointer wraps to 0 on its own.
                    if (wptr_q == '1) begin
                        state_d     = CTRL_RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = CTRL_RUN;
        endcase
    end

    // Read data is captured only for the grantee and held until its next response.
    always_comb begin
        fetch_resp_valid_d = fetch_grant;
        fetch_resp_data_d  = fetch_grant ? mem_rdata : fetch_resp_data_q;
        dbg_resp_valid_d   = dbg_grant;
        dbg_resp_data_d    = dbg_grant ? mem_rdata : dbg_resp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= CTRL_RUN;
            wptr_q             <= '0;
            load_done_q        <= 1'b0;
            fetch_resp_valid_q <= 1'b0;
            fetch_resp_data_q  <= '0;
            dbg_resp_valid_q   <= 1'b0;
            dbg_resp_data_q    <= '0;
        end else begin
            state_q            <= state_d;
            wptr_q             <= wptr_d;
            load_done_q        <= load_done_d;
            fetch_resp_valid_q <= fetch_resp_valid_d;
            fetch_resp_data_q  <= fetch_resp_data_d;
            dbg_resp_valid_q   <= dbg_resp_valid_d;
            dbg_resp_data_q    <= dbg_resp_data_d;
        end
    end

    assign fetch_req_ready  = fetch_grant;
    assign dbg_req_ready    = dbg_grant;
    assign mem_raddr        = dbg_grant ? dbg_req_addr : fetch_req_addr;
    assign mem_waddr        = wptr_q;
    assign mem_wdata        = load_data;
    assign loading          = (state_q == CTRL_LOAD);
    assign load_done        = load_done_q;
    assign fetch_resp_valid = fetch_resp_valid_q;
    assign fetch_resp_data  = fetch_resp_data_q;
    assign dbg_resp_valid   = dbg_resp_valid_q;
    assign dbg_resp_data    = dbg_resp_data_q;

endmodule
